fft_frame_sequencer: RTL and testbench



---
 rtl/fft_frame_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// Frames audio samples from the async FIFO read side into FFT_SIZE-sample
// Avalon-ST packets for the FFT sink, one frame in flight at a time.
module fft_frame_sequencer #(
    parameter int unsigned SAMPLE_WIDTH   = 24,
    parameter int unsigned FFT_SIZE_WIDTH = 10,
    parameter int unsigned FFT_SIZE       = 1 << FFT_SIZE_WIDTH
) (
    input  logic                    MCLK,
    input  logic                    RESET,
    input  logic                    enable,
    input  logic                    fifo_empty,
    input  logic [SAMPLE_WIDTH-1:0] fifo_data,
    output logic                    fifo_rd_en,
    input  logic                    sink_ready,
    output logic [SAMPLE_WIDTH-1:0] sink_real,
    output logic [SAMPLE_WIDTH-1:0] sink_imag,
    output logic                    sink_valid,
    output logic                    sink_sop,
    output logic                    sink_eop,
    input  logic                    source_valid,
    input  logic                    source_eop,
    input  logic [1:0]              source_error,
    output logic                    busy,
    output logic [15:0]             frame_count,
    output logic [15:0]             drop_count,
    output logic                    error
);

    localparam logic [FFT_SIZE_WIDTH-1:0] LAST_IDX = FFT_SIZE_WIDTH'(FFT_SIZE - 1);
    localparam logic [15:0]               DROP_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_SRC = 2'd2
    } state_t;

    state_t                    r_state;
    logic                      r_rd_pend;
    logic                      r_pend_drop;
    logic                      r_valid;
    logic                      r_sop;
    logic                      r_eop;
    logic                      r_busy;
    logic                      r_error;
    logic [SAMPLE_WIDTH-1:0]   r_real;
    logic [FFT_SIZE_WIDTH-1:0] r_cnt;
    logic [15:0]               r_frame_count;
    logic [15:0]               r_drop_count;

    logic w_xfer;
    logic w_src_done;
    logic w_rd_en;

    assign w_xfer     = r_valid && sink_ready;
    assign w_src_done = (r_state == ST_WAIT_SRC) && source_valid && source_eop;

    // Read strobe: one read in flight; in STREAM only into a free (or freeing)
    // output register and never in the eop cycle; elsewhere drain to drop.
    always_comb begin
        w_rd_en = 1'b0;
        if (!RESET && !fifo_empty && !r_rd_pend) begin
            if (r_state == ST_STREAM) begin
                w_rd_en = (!r_valid || w_xfer) && !(w_xfer && r_eop);
            end else begin
                w_rd_en = 1'b1;
            end
        end
    end

    // Read pipeline, output register, counters and frame sequencing.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_rd_pend     <= 1'b0;
            r_pend_drop   <= 1'b0;
            r_valid       <= 1'b0;
            r_sop         <= 1'b0;
            r_eop         <= 1'b0;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
            r_real        <= '0;
            r_cnt         <= '0;
            r_frame_count <= '0;
            r_drop_count  <= '0;
        end else begin
            r_rd_pend <= w_rd_en;
            // A read's fate is fixed by the state it was issued in.
            if (w_rd_en) begin
                r_pend_drop <= (r_state != ST_STREAM);
            end

            // Returned word either fills the (always empty) register or is dropped.
            if (r_rd_pend && !r_pend_drop) begin
                r_valid <= 1'b1;
                r_real  <= fifo_data;
                r_sop   <= (r_cnt == '0);
                r_eop   <= (r_cnt == LAST_IDX);
            end else if (w_xfer) begin
                r_valid <= 1'b0;
                r_sop   <= 1'b0;
                r_eop   <= 1'b0;
            end

            if (r_rd_pend && r_pend_drop && (r_drop_count != DROP_MAX)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end

            if (source_valid && (source_error != 2'b00)) begin
                r_error <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (enable && !r_rd_pend) begin
                        r_state <= ST_STREAM;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt + FFT_SIZE_WIDTH'(1);
                        if (r_eop) begin
                            r_state <= ST_WAIT_SRC;
                        end
                    end
                end
                ST_WAIT_SRC: begin
                    if (w_src_done) begin
                        r_frame_count <= r_frame_count + 16'd1;
                        r_cnt         <= '0;
                        if (enable) begin
                            r_state <= ST_STREAM;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en  = w_rd_en;
    assign sink_real   = r_real;
    assign sink_imag   = '0;
    assign sink_valid  = r_valid;
    assign sink_sop    = r_sop;
    assign sink_eop    = r_eop;
    assign busy        = r_busy;
    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;
    assign error       = r_error;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: behavioural FIFO, sink scoreboard,
// and source-side stimulus, all stepped from one initial block.
module tb_fft_frame_sequencer;

    localparam int unsigned SW       = 24;
    localparam int unsigned FFT_SIZE = 1024;

    logic          MCLK = 1'b0;
    logic          RESET;
    logic          enable;
    logic          fifo_empty;
    logic [SW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic          sink_ready;
    logic [SW-1:0] sink_real;
    logic [SW-1:0] sink_imag;
    logic          sink_valid;
    logic          sink_sop;
    logic          sink_eop;
    logic          source_valid;
    logic          source_eop;
    logic [1:0]    source_error;
    logic          busy;
    logic [15:0]   frame_count;
    logic [15:0]   drop_count;
    logic          error;

    fft_frame_sequencer dut (
        .MCLK         (MCLK),
        .RESET        (RESET),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_rd_en   (fifo_rd_en),
        .sink_ready   (sink_ready),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .source_valid (source_valid),
        .source_eop   (source_eop),
        .source_error (source_error),
        .busy         (busy),
        .frame_count  (frame_count),
        .drop_count   (drop_count),
        .error        (error)
    );

    always #10 MCLK = ~MCLK;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [SW-1:0] fifo_q[$];
    logic [SW-1:0] exp_q[$];
    int            word_seq    = 0;
    int            feed_left   = 0;
    int            feed_period = 1;
    int            feed_ctr    = 0;
    logic          feed_expect = 1'b0;
    logic          rand_ready  = 1'b0;
    logic          chk_no_valid = 1'b0;
    int            n_pops      = 0;
    int            frame_xfers = 0;
    int            total_xfers = 0;
    int            frames_done = 0;
    logic          stall_prev  = 1'b0;
    logic [SW-1:0] held_real   = '0;
    logic          held_sop    = 1'b0;
    logic          held_eop    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [SW-1:0] word_of(input int n);
        return SW'(n * 7919 + 32'h0012_3456);
    endfunction

    // One clock: check the sink at negedge, then model FIFO/feeder after posedge.
    task automatic tick();
        logic          rd_s;
        logic [SW-1:0] exp_w;
        @(negedge MCLK);
        rd_s = fifo_rd_en;
        if (!RESET) begin
            if (stall_prev) begin
                chk("hold_valid", 32'(sink_valid), 32'd1);
                chk("hold_real",  32'(sink_real),  32'(held_real));
                chk("hold_sop",   32'(sink_sop),   32'(held_sop));
                chk("hold_eop",   32'(sink_eop),   32'(held_eop));
            end
            if (sink_valid && sink_ready) begin
                chk("exp_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    chk("sink_real", 32'(sink_real), 32'(exp_w));
                    chk("sink_sop",  32'(sink_sop),  32'(frame_xfers == 0));
                    chk("sink_eop",  32'(sink_eop),  32'(frame_xfers == FFT_SIZE - 1));
                end
                total_xfers++;
                if (frame_xfers == FFT_SIZE - 1) begin
                    frame_xfers = 0;
                    frames_done++;
                end else begin
                    frame_xfers++;
                end
            end
            if (chk_no_valid) chk("no_valid", 32'(sink_valid), 32'd0);
            stall_prev = sink_valid && !sink_ready;
            held_real  = sink_real;
            held_sop   = sink_sop;
            held_eop   = sink_eop;
        end
        @(posedge MCLK);
        #1;
        if (rd_s) begin
            chk("rd_nonempty", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
            n_pops++;
        end
        if (feed_left > 0) begin
            if (feed_ctr == 0) begin
                fifo_q.push_back(word_of(word_seq));
                if (feed_expect) exp_q.push_back(word_of(word_seq));
                word_seq++;
                feed_left--;
            end
            feed_ctr = (feed_ctr + 1 == feed_period) ? 0 : feed_ctr + 1;
        end
        if (rand_ready) sink_ready = 1'($urandom_range(0, 1));
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_feed(input int n, input int period, input logic expect_out);
        feed_left   = n;
        feed_period = period;
        feed_ctr    = 0;
        feed_expect = expect_out;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int b = 0;
        while (frames_done < target && b < budget) begin
            tick();
            b++;
        end
        chk("frame_timeout", 32'(frames_done >= target), 32'd1);
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int b = 0;
        while (total_xfers < target && b < budget) begin
            tick();
            b++;
        end
        chk("xfer_timeout", 32'(total_xfers >= target), 32'd1);
    endtask

    task automatic pulse_src(input logic eop, input logic [1:0] err);
        source_valid = 1'b1;
        source_eop   = eop;
        source_error = err;
        tick();
        source_valid = 1'b0;
        source_eop   = 1'b0;
        source_error = 2'b00;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(sink_valid),  32'd0);
        chk({tag, "_sop"},   32'(sink_sop),    32'd0);
        chk({tag, "_eop"},   32'(sink_eop),    32'd0);
        chk({tag, "_real"},  32'(sink_real),   32'd0);
        chk({tag, "_rd"},    32'(fifo_rd_en),  32'd0);
        chk({tag, "_busy"},  32'(busy),        32'd0);
        chk({tag, "_fc"},    32'(frame_count), 32'd0);
        chk({tag, "_dc"},    32'(drop_count),  32'd0);
        chk({tag, "_err"},   32'(error),       32'd0);
    endtask

    initial begin
        int base;
        RESET        = 1'b0;
        enable       = 1'b0;
        fifo_empty   = 1'b1;
        fifo_data    = '0;
        sink_ready   = 1'b1;
        source_valid = 1'b0;
        source_eop   = 1'b0;
        source_error = 2'b00;

        // Asynchronous reset at time zero, before any clock edge.
        #2 RESET = 1'b1;
        #1 check_reset_outputs("rst0");
        ticks(3);
        RESET = 1'b0;
        ticks(2);
        chk("idle_busy", 32'(busy), 32'd0);

        // Frame 1: free-flowing FIFO, sink always ready.
        enable = 1'b1;
        tick();
        chk("stream_busy", 32'(busy), 32'd1);
        start_feed(FFT_SIZE, 1, 1'b1);
        wait_frames(1, 6000);
        chk("f1_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("sink_imag", 32'(sink_imag), 32'd0);
        base = total_xfers;
        chk_no_valid = 1'b1;
        ticks(50);
        chk_no_valid = 1'b0;
        chk("wait_no_xfer", 32'(total_xfers), 32'(base));
        chk("wait_busy", 32'(busy), 32'd1);
        chk("f1_fc_before", 32'(frame_count), 32'd0);
        pulse_src(1'b1, 2'b00);
        chk("f1_fc", 32'(frame_count), 32'd1);
        chk("f1_dc", 32'(drop_count), 32'd0);

        // Frame 2: random backpressure.
        rand_ready = 1'b1;
        start_feed(FFT_SIZE, 1, 1'b1);
        wait_frames(2, 12000);
        rand_ready = 1'b0;
        sink_ready = 1'b1;
        chk("f2_exp_empty", 32'(exp_q.size()), 32'd0);
        pulse_src(1'b1, 2'b00);
        chk("f2_fc", 32'(frame_count), 32'd2);

        // Frame 3, then a long source stall with slow FIFO traffic to drop.
        start_feed(FFT_SIZE, 1, 1'b1);
        wait_frames(3, 6000);
        n_pops = 0;
        chk_no_valid = 1'b1;
        start_feed(300, 10, 1'b0);
        ticks(3010);
        chk_no_valid = 1'b0;
        chk("drop_reads", 32'(n_pops), 32'd300);
        chk("drop_count", 32'(drop_count), 32'(n_pops));
        chk("drop_busy", 32'(busy), 32'd1);
        pulse_src(1'b1, 2'b00);
        chk("f3_fc", 32'(frame_count), 32'd3);

        // Frame 4: enable drops mid-frame, spurious source_eop during STREAM.
        base = total_xfers;
        start_feed(FFT_SIZE, 1, 1'b1);
        wait_xfers(base + 500, 3000);
        enable = 1'b0;
        wait_xfers(base + 600, 3000);
        pulse_src(1'b1, 2'b00);
        chk("spurious_fc", 32'(frame_count), 32'd3);
        wait_frames(4, 6000);
        chk("f4_len", 32'(total_xfers - base), 32'(FFT_SIZE));
        chk("f4_busy", 32'(busy), 32'd1);
        pulse_src(1'b1, 2'b00);
        chk("f4_fc", 32'(frame_count), 32'd4);
        chk("f4_idle", 32'(busy), 32'd0);
        ticks(5);
        chk("f4_stay_idle", 32'(busy), 32'd0);

        // Sticky error, then reset mid-frame.
        pulse_src(1'b0, 2'b01);
        chk("err_set", 32'(error), 32'd1);
        ticks(5);
        chk("err_sticky", 32'(error), 32'd1);
        enable = 1'b1;
        tick();
        base = total_xfers;
        start_feed(FFT_SIZE, 1, 1'b1);
        wait_xfers(base + 700, 3000);
        chk("err_still", 32'(error), 32'd1);
        #3 RESET = 1'b1;
        #1 check_reset_outputs("rst_mid");
        fifo_q.delete();
        exp_q.delete();
        feed_left   = 0;
        fifo_empty  = 1'b1;
        frame_xfers = 0;
        stall_prev  = 1'b0;
        ticks(3);
        RESET = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd1);
        base = frames_done;
        start_feed(FFT_SIZE, 1, 1'b1);
        wait_frames(base + 1, 6000);
        chk("f5_exp_empty", 32'(exp_q.size()), 32'd0);
        pulse_src(1'b1, 2'b00);
        chk("f5_fc", 32'(frame_count), 32'd1);
        chk("f5_err", 32'(error), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
